// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: EX-stage multiply/divide sequencer that owns the HI/LO write port.
// Performs a one-cycle registered multiply or a one-bit-per-cycle restoring divide on magnitudes.
module hilo_mdu_ctrl #(
    parameter int DIV_ITER = 32,
    parameter int OP_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs_data,
    input  logic [31:0]     rt_data,
    input  logic            flush,
    input  logic            hold,
    output logic            stallreq,
    output logic            busy,
    output logic [1:0]      hilo_we,
    output logic            hilo_en,
    output logic [63:0]     hilo_data
);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(3'd1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(3'd2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3'd3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3'd4);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(3'd5);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(3'd6);
    localparam int              CNT_W    = $clog2(DIV_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q, b_q, quot_q, rem_q, dvs_q, hi_q, lo_q;
    logic             sgn_q, qneg_q, rneg_q;

    logic             is_md_s, is_mul_s, is_sgn_s, ge_s;
    logic [63:0]      ext_a_s, ext_b_s, prod_d;
    logic [32:0]      rem_sh_s;
    logic [31:0]      rem_d, quot_d, hi_fin_d, lo_fin_d;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign is_mul_s = (op == OP_MULT) || (op == OP_MULTU);
    assign is_md_s  = is_mul_s || (op == OP_DIV) || (op == OP_DIVU);
    assign is_sgn_s = (op == OP_MULT) || (op == OP_DIV);

    // Datapath: product of the latched operands and one restoring-divide step.
    always_comb begin
        ext_a_s  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b_s  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod_d   = ext_a_s * ext_b_s;
        rem_sh_s = {rem_q, quot_q[31]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_d  = rem_sh_s[31:0] - dvs_q;
            quot_d = {quot_q[30:0], 1'b1};
        end else begin
            rem_d  = rem_sh_s[31:0];
            quot_d = {quot_q[30:0], 1'b0};
        end
        lo_fin_d = qneg_q ? (32'd0 - quot_d) : quot_d;
        hi_fin_d = rneg_q ? (32'd0 - rem_d) : rem_d;
    end

    // Sequencer state, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_md_s) begin
                        a_q     <= rs_data;
                        b_q     <= rt_data;
                        sgn_q   <= is_sgn_s;
                        quot_q  <= mag(rs_data, is_sgn_s);
                        dvs_q   <= mag(rt_data, is_sgn_s);
                        rem_q   <= 32'd0;
                        qneg_q  <= is_sgn_s && (rs_data[31] ^ rt_data[31]);
                        rneg_q  <= is_sgn_s && rs_data[31];
                        cnt_q   <= '0;
                        state_q <= is_mul_s ? S_MUL : S_DIV;
                    end
                end
                S_MUL: begin
                    hi_q    <= prod_d[63:32];
                    lo_q    <= prod_d[31:0];
                    state_q <= S_DONE;
                end
                S_DIV: begin
                    // A zero divisor short-circuits to the architected HI=rs, LO=all-ones result.
                    if (dvs_q == 32'd0) begin
                        hi_q    <= a_q;
                        lo_q    <= 32'hFFFF_FFFF;
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        quot_q <= quot_d;
                        rem_q  <= rem_d;
                        if (cnt_q == CNT_LAST) begin
                            hi_q    <= hi_fin_d;
                            lo_q    <= lo_fin_d;
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1'b1);
                        end
                    end
                end
                S_DONE: begin
                    if (!hold) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Port outputs: IDLE reacts to op in the same cycle, DONE replays the result registers.
    always_comb begin
        stallreq  = 1'b0;
        hilo_we   = 2'b00;
        hilo_en   = 1'b0;
        hilo_data = 64'd0;
        busy      = (state_q != S_IDLE);
        if (rst || flush) begin
            stallreq = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_md_s) begin
                        stallreq = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hilo_we   = 2'b10;
                        hilo_en   = 1'b1;
                        hilo_data = {rs_data, rs_data};
                    end else if (op == OP_MTLO) begin
                        hilo_we   = 2'b01;
                        hilo_en   = 1'b1;
                        hilo_data = {rs_data, rs_data};
                    end else begin
                        stallreq = 1'b0;
                    end
                end
                S_MUL, S_DIV: stallreq = 1'b1;
                S_DONE: begin
                    hilo_we   = 2'b11;
                    hilo_en   = 1'b1;
                    hilo_data = {hi_q, lo_q};
                end
                default: stallreq = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_hilo_mdu_ctrl;
    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        rst, flush, hold;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        stallreq, busy, hilo_en;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model: one pending transaction with its result and the cycle it becomes visible
    bit          m_inflight = 1'b0;
    int          m_ready    = 0;
    int          cyc        = 0;
    logic [63:0] m_res      = 64'd0;

    logic        e_stall, e_busy, e_en;
    logic [1:0]  e_we;
    logic [63:0] e_data;

    logic        s_stall, s_busy, s_en;
    logic [1:0]  s_we;
    logic [63:0] s_data;

    always #5 clk = ~clk;

    hilo_mdu_ctrl #(.DIV_ITER(DIV_ITER), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush), .hold(hold), .stallreq(stallreq), .busy(busy),
        .hilo_we(hilo_we), .hilo_en(hilo_en), .hilo_data(hilo_data)
    );

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd1 || o == 3'd2) return 2;
        if (b == 32'd0) return 2;
        return DIV_ITER + 1;
    endfunction

    function automatic void model_expect();
        e_stall = 1'b0; e_we = 2'b00; e_en = 1'b0; e_data = 64'd0;
        e_busy  = m_inflight;
        if (!(rst || flush)) begin
            if (m_inflight) begin
                if (cyc < m_ready) begin
                    e_stall = 1'b1;
                end else begin
                    e_we = 2'b11; e_en = 1'b1; e_data = m_res;
                end
            end else if (op >= 3'd1 && op <= 3'd4) begin
                e_stall = 1'b1;
            end else if (op == 3'd5) begin
                e_we = 2'b10; e_en = 1'b1; e_data = {rs_data, rs_data};
            end else if (op == 3'd6) begin
                e_we = 2'b01; e_en = 1'b1; e_data = {rs_data, rs_data};
            end
        end
    endfunction

    function automatic void model_update();
        if (rst || flush) begin
            m_inflight = 1'b0;
        end else if (m_inflight) begin
            if (cyc >= m_ready && !hold) m_inflight = 1'b0;
        end else if (op >= 3'd1 && op <= 3'd4) begin
            m_inflight = 1'b1;
            m_res      = ref_result(op, rs_data, rt_data);
            m_ready    = cyc + ref_latency(op, rt_data);
        end
        cyc++;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic h, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst = r; flush = f; hold = h; op = o; rs_data = a; rt_data = b;
        #1;
        s_stall = stallreq; s_busy = busy; s_en = hilo_en; s_we = hilo_we; s_data = hilo_data;
        if (chk_en) begin
            model_expect();
            chk("stallreq",  64'(s_stall), 64'(e_stall));
            chk("busy",      64'(s_busy),  64'(e_busy));
            chk("hilo_we",   64'(s_we),    64'(e_we));
            chk("hilo_en",   64'(s_en),    64'(e_en));
            chk("hilo_data", s_data,       e_data);
        end
        @(posedge clk);
        model_update();
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] lit, input int stalls);
        int n_st = 0;
        bit got  = 1'b0;
        chk({name, "_model"}, ref_result(o, a, b), lit);
        step(1'b0, 1'b0, 1'b0, o, a, b);
        n_st += int'(s_stall);
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, $urandom, $urandom);
            if (s_en) got = 1'b1;
            else n_st += int'(s_stall);
        end
        chk({name, "_done_seen"}, 64'(got), 64'd1);
        chk({name, "_data"}, s_data, lit);
        chk({name, "_we"}, 64'(s_we), 64'd3);
        chk({name, "_stall_cycles"}, 64'(n_st), 64'(stalls));
    endtask

    function automatic logic [31:0] rnd_opnd();
        int k = int'($urandom_range(0, 7));
        case (k)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk_en = 1'b1;

        // reset state
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("rst_busy",  64'(s_busy),  64'd0);
        chk("rst_stall", 64'(s_stall), 64'd0);
        chk("rst_we",    64'(s_we),    64'd0);
        chk("rst_en",    64'(s_en),    64'd0);
        chk("rst_data",  s_data,       64'd0);

        run_op("mult_m2x3",  3'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2);
        run_op("multu_m2x3", 3'd2, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 2);
        run_op("div_m7d2",   3'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_ITER + 1);
        run_op("divu_100d7", 3'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIV_ITER + 1);
        run_op("divu_by0",   3'd4, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 2);
        run_op("div_by0",    3'd3, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 2);
        run_op("div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_ITER + 1);

        // mthi / mtlo pass-through in IDLE
        step(1'b0, 1'b0, 1'b0, 3'd5, 32'hA5A5_A5A5, 32'd0);
        chk("mthi_we",    64'(s_we),    64'd2);
        chk("mthi_en",    64'(s_en),    64'd1);
        chk("mthi_stall", 64'(s_stall), 64'd0);
        chk("mthi_data",  s_data,       64'hA5A5_A5A5_A5A5_A5A5);
        step(1'b0, 1'b0, 1'b0, 3'd6, 32'h5A5A_0F0F, 32'd0);
        chk("mtlo_we",    64'(s_we),    64'd1);
        chk("mtlo_data",  s_data,       64'h5A5A_0F0F_5A5A_0F0F);

        // flush at divide iteration 10
        step(1'b0, 1'b0, 1'b0, 3'd4, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("flush_en",    64'(s_en),    64'd0);
        chk("flush_stall", 64'(s_stall), 64'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("flush_busy_after", 64'(s_busy), 64'd0);
        chk("flush_en_after",   64'(s_en),   64'd0);
        run_op("mult_after_flush", 3'd1, 32'd12345, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7, 2);

        // hold in DONE for 3 cycles
        step(1'b0, 1'b0, 1'b0, 3'd2, 32'd7, 32'd6);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 3'd2, 32'd9, 32'd9);
            chk("hold_data", s_data, 64'd42);
            chk("hold_en",   64'(s_en), 64'd1);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("hold_release_data", s_data, 64'd42);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("hold_idle_busy", 64'(s_busy), 64'd0);
        chk("hold_idle_en",   64'(s_en),   64'd0);

        // reset during MUL
        step(1'b0, 1'b0, 1'b0, 3'd1, 32'd5, 32'd5);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        chk("rstmul_busy",  64'(s_busy),  64'd0);
        chk("rstmul_stall", 64'(s_stall), 64'd0);
        chk("rstmul_en",    64'(s_en),    64'd0);
        chk("rstmul_data",  s_data,       64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, f, h;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 49) == 0);
            h = ($urandom_range(0, 2) == 0);
            step(r, f, h, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Multiply/divide sequencer for the HI/LO resource, located in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
- Runs a registered multiply or a 32-iteration restoring divide.
- Raises a pipeline stall request while busy.
- Drives the HI/LO write port: hilo_we/hilo_en/hilo_data, with the same encoding the regfile forwarding network consumes.

Parameters:
DIV_ITER, 32, number of divide iterations (one quotient bit per cycle)
OP_W, 3, width of op code

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
rs_data  in  32  dividend / multiplicand / mthi-mtlo source
rt_data  in  32  divisor / multiplier
flush  in  1  cancel in-flight operation (exception/branch flush)
hold  in  1  downstream stall; freezes result in DONE
stallreq  out  1  request EX-and-earlier stall
busy  out  1  state != IDLE
hilo_we  out  2  11 write HI+LO, 10 HI only, 01 LO only, 00 none
hilo_en  out  1  hilo_data valid this cycle
hilo_data  out  64  {HI,LO}

Behaviour:
- Reset
  - State IDLE; counter = 0; product/quotient/remainder regs = 0.
  - Outputs: stallreq=0, busy=0, hilo_we=00, hilo_en=0, hilo_data=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE
  - op mult/multu/div/divu: latch rs_data, rt_data and op; stallreq=1 combinationally in the same cycle. Mult ops go to MUL, div ops go to DIV.
  - op mthi: combinational pass-through, no stall. hilo_we=10, hilo_en=1, hilo_data={rs_data,rs_data}.
  - op mtlo: combinational pass-through, no stall. hilo_we=01, hilo_en=1, hilo_data={rs_data,rs_data}.
  - Any other op: outputs zero.
- MUL (1 cycle)
  - Register the 64-bit product: signed for mult, unsigned for multu.
  - stallreq=1. Next state DONE.
- DIV
  - Unsigned restoring divide on operand magnitudes, one bit per cycle for DIV_ITER cycles; counter 0..DIV_ITER-1. stallreq=1. Go to DONE after the last iteration.
  - Signed div: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor == 0: DIV lasts exactly 1 cycle, then DONE with HI=rs_data, LO=32'hFFFF_FFFF, for both signed and unsigned.
- DONE
  - stallreq=0, hilo_we=11, hilo_en=1, hilo_data={HI,LO} from result regs.
  - hold=1: stay in DONE with outputs held; the repeated write is idempotent.
  - hold=0: go to IDLE next cycle.
  - The op still presented in DONE (the same, now released instruction) never restarts the unit. It is not re-sampled until the cycle after DONE.
- Latency (start accepted in cycle T)
  - mult/multu: stallreq high in T and T+1; result valid in T+2.
  - div/divu: stallreq high for T..T+DIV_ITER; result valid in T+DIV_ITER+1.
  - Divide by zero: result valid in T+2.
- flush
  - Has priority over everything except rst; synchronous.
  - Next state IDLE, counter cleared, no HI/LO write is ever emitted for the cancelled op.
  - In the flush cycle itself: hilo_en=0, hilo_we=00, stallreq=0.
- rst mid-operation: identical to flush, and all datapath regs are cleared.
- busy=1 in MUL, DIV and DONE.
- hilo_en=0 whenever hilo_we=00.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 → stallreq high 2 cycles; DONE: hilo_we=11, hilo_data=64'hFFFFFFFF_FFFFFFFA. Same operands with multu → 64'h00000002_FFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 → stallreq high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD. divu 100/7 → HI=2, LO=14.
- divu rt=0, rs=0x1234 → result 2 cycles after start: HI=0x1234, LO=0xFFFFFFFF. Signed 0x80000000/-1 → LO=0x80000000, HI=0.
- mthi rs=0xA5A5A5A5 in IDLE → same cycle hilo_we=10, hilo_en=1, stallreq=0; mtlo → hilo_we=01.
- flush at DIV iteration 10 → next cycle IDLE, busy=0, no hilo_en pulse ever observed; a new mult issued immediately afterwards completes normally.
- hold=1 for 3 cycles in DONE → outputs stable for 3 cycles, single transition to IDLE after hold drops; rst asserted during MUL → all outputs 0 next cycle.
